// File: rtl/v6_filter_ctrl_pkg.sv
// Shared types and defaults for the v6 filter run controller.
// SIZE_ADC_DATA mirrors the ADC sample width used across the v6 chain.
package v6_filter_ctrl_pkg;
  localparam int SIZE_ADC_DATA = 12;
  localparam int V6_FLUSH_CYC  = 16;
  localparam int V6_SETTLE_CYC = 64;
  localparam int V6_DEAD_CYC   = 32;
  localparam int V6_PEAK_MAX   = 255;
  localparam int V6_TS_W       = 32;
  localparam int V6_TMR_W      = 16;

  typedef enum logic [2:0] {IDLE, FLUSH, SETTLE, ARMED, PEAK, REPORT, DEAD} v6_ctrl_state_t;

  // Down-counter preset for an N-cycle phase; a zero-length phase presets to 0.
  function automatic logic [V6_TMR_W-1:0] tmr_preset(input int cyc);
    return (cyc <= 0) ? '0 : V6_TMR_W'(cyc - 1);
  endfunction
endpackage

// File: rtl/v6_filter_ctrl_if.sv
// Event readout channel: controller (master) presents a captured peak,
// readout (slave) accepts it with evt_ready.
interface v6_filter_ctrl_if import v6_filter_ctrl_pkg::*; #(parameter int TS_W = V6_TS_W) ();
  logic                     evt_valid;
  logic                     evt_ready;
  logic [SIZE_ADC_DATA-1:0] evt_amp;
  logic [TS_W-1:0]          evt_ts;
  logic                     evt_ovf;

  modport master (output evt_valid, evt_amp, evt_ts, evt_ovf, input evt_ready);
  modport slave  (input evt_valid, evt_amp, evt_ts, evt_ovf, output evt_ready);
endinterface

// File: rtl/v6_filter_ctrl_timer.sv
// Loadable down-counter with zero flag; one instance times FLUSH, SETTLE and DEAD.
module v6_filter_ctrl_timer import v6_filter_ctrl_pkg::*; (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [V6_TMR_W-1:0] load_val,
  output logic                zero
);
  logic [V6_TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/v6_filter_ctrl.sv
// Run controller for the v6 trapezoidal filter: flush, settle, then capture
// threshold pulses (peak amplitude + timestamp) and hand them to readout.
module v6_filter_ctrl import v6_filter_ctrl_pkg::*; #(
  parameter int FLUSH_CYC  = V6_FLUSH_CYC,
  parameter int SETTLE_CYC = V6_SETTLE_CYC,
  parameter int DEAD_CYC   = V6_DEAD_CYC,
  parameter int PEAK_MAX   = V6_PEAK_MAX,
  parameter int TS_W       = V6_TS_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [SIZE_ADC_DATA-1:0] threshold,
  input  logic [SIZE_ADC_DATA-1:0] filt_data,
  output logic                     filt_rst_n,
  output logic                     busy,
  v6_filter_ctrl_if.master         evt
);
  localparam int LEN_W = (PEAK_MAX < 2) ? 1 : $clog2(PEAK_MAX);
  localparam logic [V6_TMR_W-1:0] FLUSH_LD  = tmr_preset(FLUSH_CYC);
  localparam logic [V6_TMR_W-1:0] SETTLE_LD = tmr_preset(SETTLE_CYC);
  localparam logic [V6_TMR_W-1:0] DEAD_LD   = tmr_preset(DEAD_CYC);

  v6_ctrl_state_t           state;
  logic [TS_W-1:0]          ts, ts_pk;
  logic [SIZE_ADC_DATA-1:0] amp;
  logic [LEN_W-1:0]         len;
  logic                     stop_lat;
  logic                     tmr_load, tmr_zero;
  logic [V6_TMR_W-1:0]      tmr_val;

  wire accept   = evt.evt_valid & evt.evt_ready;
  wire stop_any = stop | stop_lat;
  wire above    = filt_data > threshold;
  wire new_max  = filt_data > amp;

  // Timer presets must land on the same edge as the state change they time.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE:    if (start)                  begin tmr_load = 1'b1; tmr_val = FLUSH_LD;  end
      FLUSH:   if (!stop && tmr_zero)      begin tmr_load = 1'b1; tmr_val = SETTLE_LD; end
      REPORT:  if (accept && !stop_any && DEAD_CYC != 0)
                                           begin tmr_load = 1'b1; tmr_val = DEAD_LD;   end
      default: ;
    endcase
  end

  v6_filter_ctrl_timer u_timer (
    .clk(clk), .reset(reset), .load(tmr_load), .load_val(tmr_val), .zero(tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      filt_rst_n    <= 1'b1;
      busy          <= 1'b0;
      evt.evt_valid <= 1'b0;
      evt.evt_amp   <= '0;
      evt.evt_ts    <= '0;
      evt.evt_ovf   <= 1'b0;
      ts            <= '0;
      ts_pk         <= '0;
      amp           <= '0;
      len           <= '0;
      stop_lat      <= 1'b0;
    end else begin
      if (state inside {ARMED, PEAK, REPORT, DEAD}) ts <= ts + 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= FLUSH; filt_rst_n <= 1'b0; busy <= 1'b1;
        end
        FLUSH: if (stop) begin
          state <= IDLE; filt_rst_n <= 1'b1; busy <= 1'b0;
        end else if (tmr_zero) begin
          state <= SETTLE; filt_rst_n <= 1'b1;
        end
        SETTLE: if (stop) begin
          state <= IDLE; busy <= 1'b0;
        end else if (tmr_zero) begin
          state <= ARMED; ts <= '0;
        end
        ARMED: if (stop) begin
          state <= IDLE; busy <= 1'b0;
        end else if (above) begin
          state <= PEAK; amp <= filt_data; ts_pk <= ts; len <= '0;
        end
        PEAK: if (stop) begin
          state <= IDLE; busy <= 1'b0; filt_rst_n <= 1'b1;
        end else if (!above) begin
          state <= REPORT; evt.evt_valid <= 1'b1;
          evt.evt_amp <= amp; evt.evt_ts <= ts_pk; evt.evt_ovf <= 1'b0;
        end else if (len == LEN_W'(PEAK_MAX - 1)) begin
          // Overflow exit still counts the current sample toward the peak.
          state <= REPORT; evt.evt_valid <= 1'b1;
          evt.evt_amp <= new_max ? filt_data : amp;
          evt.evt_ts  <= new_max ? ts : ts_pk;
          evt.evt_ovf <= 1'b1;
        end else begin
          if (new_max) begin amp <= filt_data; ts_pk <= ts; end
          len <= len + 1'b1;
        end
        REPORT: begin
          if (stop) stop_lat <= 1'b1;
          if (accept) begin
            evt.evt_valid <= 1'b0;
            stop_lat      <= 1'b0;
            if (stop_any) begin
              state <= IDLE; busy <= 1'b0;
            end else if (DEAD_CYC == 0) state <= ARMED;
            else                        state <= DEAD;
          end
        end
        DEAD: if (stop) begin
          state <= IDLE; busy <= 1'b0;
        end else if (tmr_zero) state <= ARMED;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_v6_filter_ctrl.sv
// Bench for v6_filter_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a phase/duration model of the controller.
module tb_v6_filter_ctrl;
  localparam int DW = v6_filter_ctrl_pkg::SIZE_ADC_DATA;
  localparam int FL = 4, ST = 8, DT = 3, PM = 6, TW = 8;
  localparam int M_IDLE = 0, M_FL = 1, M_ST = 2, M_ARM = 3, M_PEAK = 4, M_REP = 5, M_DEAD = 6;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0, ready = 1'b0;
  logic [DW-1:0] threshold = DW'(100), filt_data = '0;
  logic filt_rst_n, busy;
  int checks = 0, failures = 0;

  v6_filter_ctrl_if #(.TS_W(TW)) evt ();
  assign evt.evt_ready = ready;

  v6_filter_ctrl #(.FLUSH_CYC(FL), .SETTLE_CYC(ST), .DEAD_CYC(DT), .PEAK_MAX(PM), .TS_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .threshold(threshold),
    .filt_data(filt_data), .filt_rst_n(filt_rst_n), .busy(busy), .evt(evt)
  );

  always #5 clk = ~clk;

  // Model: current phase, cycles left in a timed phase, running timestamp,
  // peak being built, and the event on offer.
  int ph, left, mts, pamp, pts, plen, ramp, rts;
  bit spend, mfrn, mbusy, mvalid, rovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = M_IDLE; left = 0; mts = 0; pamp = 0; pts = 0; plen = 0;
    ramp = 0; rts = 0; rovf = 0; spend = 0; mfrn = 1; mbusy = 0; mvalid = 0;
  endtask

  task automatic go_idle();
    ph = M_IDLE; mfrn = 1; spend = 0;
  endtask

  task automatic report(input bit ovf);
    ph = M_REP; mvalid = 1; ramp = pamp; rts = pts; rovf = ovf;
  endtask

  task automatic model_step();
    int ots = mts;
    if (ph == M_ARM || ph == M_PEAK || ph == M_REP || ph == M_DEAD) mts = (mts + 1) % (1 << TW);
    case (ph)
      M_IDLE: if (start) begin ph = M_FL; left = FL; mfrn = 0; end
      M_FL: if (stop) go_idle();
            else begin left--; if (left == 0) begin ph = M_ST; left = ST; mfrn = 1; end end
      M_ST: if (stop) go_idle();
            else begin left--; if (left == 0) begin ph = M_ARM; mts = 0; end end
      M_ARM: if (stop) go_idle();
             else if (int'(filt_data) > int'(threshold)) begin
               ph = M_PEAK; pamp = filt_data; pts = ots; plen = 0;
             end
      M_PEAK: if (stop) go_idle();
              else begin
                plen++;
                if (int'(filt_data) > pamp) begin pamp = filt_data; pts = ots; end
                if (int'(filt_data) <= int'(threshold)) report(0);
                else if (plen == PM) report(1);
              end
      M_REP: begin
        if (stop) spend = 1;
        if (ready) begin
          mvalid = 0;
          if (spend) go_idle();
          else if (DT == 0) ph = M_ARM;
          else begin ph = M_DEAD; left = DT; end
        end
      end
      M_DEAD: if (stop) go_idle();
              else begin left--; if (left == 0) ph = M_ARM; end
      default: go_idle();
    endcase
    mbusy = (ph != M_IDLE);
  endtask

  task automatic compare();
    chk("filt_rst_n", filt_rst_n, mfrn);
    chk("busy", busy, mbusy);
    chk("evt_valid", evt.evt_valid, mvalid);
    if (mvalid) begin
      chk("evt_amp", evt.evt_amp, ramp);
      chk("evt_ts", evt.evt_ts, rts);
      chk("evt_ovf", evt.evt_ovf, rovf);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_frn"}, filt_rst_n, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, evt.evt_valid, 0);
    chk({tag, "_amp"}, evt.evt_amp, 0);
    chk({tag, "_ts"}, evt.evt_ts, 0);
    chk({tag, "_ovf"}, evt.evt_ovf, 0);
  endtask

  // Returns cycles spent; an expired bound is a failed comparison.
  task automatic wait_armed(output int n);
    n = 0;
    while (ph != M_ARM && n < 60) begin cycle(); n++; end
    if (ph != M_ARM) chk("wait_armed_timeout", 0, 1);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_reset_vals(tag);
    model_reset();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    int n, lowc, pls;
    int seq[5] = '{50, 120, 180, 150, 90};
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    // 1: flush/settle timing
    start = 1'b1; cycle(); start = 1'b0;
    chk("busy_after_start", busy, 1);
    lowc = (filt_rst_n == 1'b0) ? 1 : 0;
    n = 0;
    while (ph != M_ARM && n < 60) begin cycle(); n++; if (!filt_rst_n) lowc++; end
    chk("flush_low_cycles", lowc, 4);
    chk("armed_latency", n + 1, 13);

    // 2: basic pulse
    foreach (seq[i]) begin filt_data = DW'(seq[i]); cycle(); end
    chk("t2_valid", evt.evt_valid, 1);
    chk("t2_amp", evt.evt_amp, 180);
    chk("t2_ts", evt.evt_ts, 2);
    chk("t2_ovf", evt.evt_ovf, 0);

    // 3: backpressure, then deadtime ignores a pulse
    filt_data = DW'(250);
    repeat (5) cycle();
    chk("t3_hold_valid", evt.evt_valid, 1);
    chk("t3_hold_amp", evt.evt_amp, 180);
    chk("t3_hold_ts", evt.evt_ts, 2);
    ready = 1'b1; cycle(); ready = 1'b0;
    chk("t3_accepted", evt.evt_valid, 0);
    repeat (3) cycle();
    filt_data = DW'(50);
    repeat (4) cycle();
    chk("t3_no_retrigger", evt.evt_valid, 0);

    // 4: peak overflow
    filt_data = DW'(200);
    n = 0;
    while (!evt.evt_valid && n < 20) begin cycle(); n++; end
    chk("t4_ovf_latency", n, 7);
    chk("t4_ovf", evt.evt_ovf, 1);
    chk("t4_amp", evt.evt_amp, 200);
    filt_data = '0;
    ready = 1'b1; cycle(); ready = 1'b0;
    repeat (4) cycle();

    // 5a: stop in PEAK discards the event
    filt_data = DW'(200); cycle(); cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    chk("t5_stop_peak_busy", busy, 0);
    chk("t5_stop_peak_valid", evt.evt_valid, 0);
    filt_data = '0; repeat (2) cycle();
    chk("t5_stop_peak_novalid", evt.evt_valid, 0);

    // 5b: stop in REPORT delivers then goes idle
    start = 1'b1; cycle(); start = 1'b0;
    wait_armed(n);
    filt_data = DW'(150); cycle(); filt_data = DW'(50); cycle();
    chk("t5_rep_amp", evt.evt_amp, 150);
    stop = 1'b1; cycle(); stop = 1'b0;
    chk("t5_rep_busy", busy, 1);
    chk("t5_rep_valid", evt.evt_valid, 1);
    ready = 1'b1; cycle(); ready = 1'b0;
    chk("t5_rep_done_valid", evt.evt_valid, 0);
    chk("t5_rep_done_busy", busy, 0);

    // 6: async reset in PEAK and in FLUSH, then a full rerun
    start = 1'b1; cycle(); start = 1'b0;
    wait_armed(n);
    filt_data = DW'(200); cycle(); cycle();
    async_reset("rst_peak");
    filt_data = '0;
    start = 1'b1; cycle(); start = 1'b0; cycle();
    async_reset("rst_flush");
    start = 1'b1; cycle(); start = 1'b0;
    wait_armed(n);
    filt_data = DW'(130); cycle(); filt_data = DW'(50); cycle();
    chk("t6_rerun_valid", evt.evt_valid, 1);
    chk("t6_rerun_amp", evt.evt_amp, 130);
    ready = 1'b1; cycle(); ready = 1'b0;

    // Random traffic
    pls = 0;
    for (int c = 0; c < 5000; c++) begin
      if (c % 600 == 0) threshold = DW'($urandom_range(80, 120));
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 180) == 0);
      ready = ($urandom_range(0, 2) != 0);
      if (pls == 0 && $urandom_range(0, 9) == 0) pls = $urandom_range(1, 9);
      if (pls > 0) begin filt_data = DW'($urandom_range(90, 260)); pls--; end
      else filt_data = DW'($urandom_range(0, 110));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
